// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: issues one ALU or LS op per cycle and books its ROB writeback slot so that completions never collide.
// Latency: grants are combinational; the writeback strobe appears ALU_LAT / LS_LAT cycles after the grant.
// Backpressure: an ungranted request simply waits (counted as a stall) while its slot is taken, a store is speculative, or it lost arbitration.
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

module fu_issue_arbiter #(
  parameter int ROB_IDX_W = `ROB_IDX_SIZE,
  parameter int ALU_LAT   = 1,
  parameter int LS_LAT    = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_alu_req,
  input  logic [ROB_IDX_W-1:0] in_alu_rob_idx,
  input  logic                 in_ls_req,
  input  logic                 in_ls_is_store,
  input  logic [ROB_IDX_W-1:0] in_ls_rob_idx,
  input  logic                 in_spec_pending,
  input  logic                 in_flush,
  output logic                 out_alu_grant,
  output logic                 out_ls_grant,
  output logic                 out_wb_valid,
  output logic [ROB_IDX_W-1:0] out_wb_rob_idx,
  output logic                 out_wb_from_ls,
  output logic                 out_busy,
  output logic [CNT_W-1:0]     out_stall_cycles
);

  // One writeback booking. Invalid entries are always all-zero, so slot 0
  // can drive the writeback outputs directly without extra masking.
  typedef struct packed {
    logic                 valid;
    logic                 from_ls;
    logic [ROB_IDX_W-1:0] rob_idx;
  } slot_t;

  // slot_q[k] holds the op that writes back k cycles from now; slot_q[0] is
  // the op whose writeback is being presented this cycle.
  slot_t [LS_LAT-1:0] slot_q, slot_d;
  logic               rr_q, rr_d;        // 0: ALU favoured, 1: LS favoured
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               alu_ok, ls_ok, ls_reserved;
  logic               alu_grant, ls_grant;
  logic [LS_LAT-1:0]  slot_vld;

  // Collect the valid bits so occupancy is a single reduction.
  for (genvar g = 0; g < LS_LAT; g++) begin : g_vld
    assign slot_vld[g] = slot_q[g].valid;
  end

  // Eligibility and single-winner grant selection.
  always_comb begin
    // An ALU op granted now lands in slot ALU_LAT-1 after the shift, i.e. it
    // collides with whatever currently sits in slot ALU_LAT (an older LS op).
    alu_ok      = in_alu_req & ~slot_q[ALU_LAT].valid;
    // Stores may not issue under an unresolved branch; loads may.
    ls_ok       = in_ls_req & ~(in_ls_is_store & in_spec_pending);
    // When it is the ALU's turn but its slot is blocked, LS is held off for
    // one cycle so the conflicting slot drains and the ALU wait stays bounded.
    ls_reserved = ~rr_q & in_alu_req & ~alu_ok;
    alu_grant   = 1'b0;
    ls_grant    = 1'b0;
    if (!in_rst && !in_flush) begin
      if (alu_ok && (!ls_ok || !rr_q)) begin
        alu_grant = 1'b1;
      end else if (ls_ok && !ls_reserved) begin
        ls_grant = 1'b1;
      end
    end
  end

  // Next state: shift the schedule, book the granted op, update turn and stall count.
  always_comb begin
    slot_d = slot_q >> $bits(slot_t);
    if (alu_grant) begin
      slot_d[ALU_LAT-1] = {1'b1, 1'b0, in_alu_rob_idx};
    end
    if (ls_grant) begin
      slot_d[LS_LAT-1] = {1'b1, 1'b1, in_ls_rob_idx};
    end

    rr_d = rr_q;
    if (alu_grant) begin
      rr_d = 1'b1;
    end else if (ls_grant) begin
      rr_d = 1'b0;
    end

    stall_d = stall_q;
    if (!in_flush && (in_alu_req || in_ls_req) && !alu_grant && !ls_grant
        && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // A flush drops every booking and hands the next turn to the ALU; the
    // stall counter is deliberately left untouched.
    if (in_flush) begin
      slot_d = '0;
      rr_d   = 1'b0;
    end
  end

  // State registers; reset drops all in-flight bookings.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      slot_q  <= '0;
      rr_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      slot_q  <= slot_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

  assign out_alu_grant    = alu_grant;
  assign out_ls_grant     = ls_grant;
  assign out_wb_valid     = slot_q[0].valid;
  assign out_wb_from_ls   = slot_q[0].from_ls;
  assign out_wb_rob_idx   = slot_q[0].rob_idx;
  assign out_busy         = |slot_vld;
  assign out_stall_cycles = stall_q;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb_fu_issue_arbiter: directed scenarios plus a randomized run against a due-cycle reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on the falling edge.
// Backpressure: requests are held or dropped by the stimulus; the model decides grants.
module tb_fu_issue_arbiter;
  localparam int W       = 6;
  localparam int ALU_LAT = 1;
  localparam int LS_LAT  = 2;
  localparam int CNT_W   = 16;

  logic             in_clk, in_rst;
  logic             in_alu_req, in_ls_req, in_ls_is_store, in_spec_pending, in_flush;
  logic [W-1:0]     in_alu_rob_idx, in_ls_rob_idx;
  logic             out_alu_grant, out_ls_grant, out_wb_valid, out_wb_from_ls, out_busy;
  logic [W-1:0]     out_wb_rob_idx;
  logic [CNT_W-1:0] out_stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         ls;
    logic [W-1:0] idx;
  } ent_t;

  fu_issue_arbiter #(.ROB_IDX_W(W), .ALU_LAT(ALU_LAT), .LS_LAT(LS_LAT), .CNT_W(CNT_W)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_alu_req(in_alu_req), .in_alu_rob_idx(in_alu_rob_idx),
    .in_ls_req(in_ls_req), .in_ls_is_store(in_ls_is_store), .in_ls_rob_idx(in_ls_rob_idx),
    .in_spec_pending(in_spec_pending), .in_flush(in_flush),
    .out_alu_grant(out_alu_grant), .out_ls_grant(out_ls_grant),
    .out_wb_valid(out_wb_valid), .out_wb_rob_idx(out_wb_rob_idx), .out_wb_from_ls(out_wb_from_ls),
    .out_busy(out_busy), .out_stall_cycles(out_stall_cycles)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {alu_grant, ls_grant, busy, wb_valid, from_ls, rob_idx}; wb fields masked when not valid.
  function automatic logic [W+4:0] obs();
    return {out_alu_grant, out_ls_grant, out_busy, out_wb_valid,
            out_wb_valid ? {out_wb_from_ls, out_wb_rob_idx} : {(W+1){1'b0}}};
  endfunction

  function automatic logic [W+4:0] mk(input int ag, input int lg, input int bz, input int v,
                                      input int ls, input int idx);
    logic [W-1:0] i;
    i = idx[W-1:0];
    return {ag[0], lg[0], bz[0], v[0], v[0] ? {ls[0], i} : {(W+1){1'b0}}};
  endfunction

  task automatic drive(input int ar, input int ai, input int lr, input int st,
                       input int li, input int sp, input int fl);
    in_alu_req      = ar[0];
    in_alu_rob_idx  = ai[W-1:0];
    in_ls_req       = lr[0];
    in_ls_is_store  = st[0];
    in_ls_rob_idx   = li[W-1:0];
    in_spec_pending = sp[0];
    in_flush        = fl[0];
  endtask

  task automatic next_cycle();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    in_rst = 1'b1;
    repeat (2) @(posedge in_clk);
    #1 in_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+4:0] e;
    in_rst = 1'b1;
    drive(1, 5, 1, 0, 6, 0, 0);
    @(posedge in_clk); #1;
    e = mk(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e || out_stall_cycles !== '0 || {out_wb_from_ls, out_wb_rob_idx} !== '0) begin
      errors++;
      $display("FAIL reset_state: got obs=%h idx=%h cnt=%0d, want obs=%h idx=0 cnt=0", obs(), out_wb_rob_idx, out_stall_cycles, e);
    end
    in_rst = 1'b0;
    @(negedge in_clk);
    e = mk(1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_alu_first: got %h want %h", obs(), e); end
    next_cycle();
    @(negedge in_clk);
    e = mk(0, 1, 1, 1, 0, 5);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_then_ls: got %h want %h", obs(), e); end
  endtask

  task automatic test_alu_stream();
    logic [W+4:0] e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive((c < 3) ? 1 : 0, 3 + c, 0, 0, 0, 0, 0);
      @(negedge in_clk);
      e = mk((c < 3) ? 1 : 0, 0, (c >= 1 && c <= 3) ? 1 : 0, (c >= 1 && c <= 3) ? 1 : 0, 0, 2 + c);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL alu_stream c%0d: got %h want %h", c, obs(), e); end
      next_cycle();
    end
  endtask

  task automatic test_ls_then_alu();
    logic [W+4:0] e;
    do_reset();
    drive(0, 0, 1, 0, 7, 0, 0); @(negedge in_clk); e = mk(0, 1, 0, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL ls_alu c0: got %h want %h", obs(), e); end
    next_cycle();
    drive(1, 2, 0, 0, 0, 0, 0); @(negedge in_clk); e = mk(0, 0, 1, 0, 0, 0);
    checks++; if (obs() !== e) begin errors++; $display("FAIL ls_alu c1: got %h want %h", obs(), e); end
    next_cycle();
    @(negedge in_clk); e = mk(1, 0, 1, 1, 1, 7);
    checks++; if (obs() !== e) begin errors++; $display("FAIL ls_alu c2: got %h want %h", obs(), e); end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0); @(negedge in_clk); e = mk(0, 0, 1, 1, 0, 2);
    checks++; if (obs() !== e) begin errors++; $display("FAIL ls_alu c3: got %h want %h", obs(), e); end
    checks++; if (out_stall_cycles !== 16'd1) begin errors++; $display("FAIL ls_alu stall: got %0d want 1", out_stall_cycles); end
    next_cycle();
  endtask

  task automatic test_both_continuous();
    logic [W+4:0] e;
    int ph, act;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      ph  = c % 3;
      act = (c < 9) ? 1 : 0;
      drive(act, 10, act, 0, 20, 0, 0);
      @(negedge in_clk);
      e = mk(act & ((ph == 0) ? 1 : 0), act & ((ph == 1) ? 1 : 0), (c >= 1) ? 1 : 0,
             (c >= 1 && ph != 2) ? 1 : 0, (ph == 0) ? 1 : 0, (ph == 0) ? 20 : 10);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL both c%0d: got %h want %h", c, obs(), e); end
      if (c == 9) begin
        checks++;
        if (out_stall_cycles !== 16'd3) begin errors++; $display("FAIL both_stall: got %0d want 3", out_stall_cycles); end
      end
      next_cycle();
    end
  endtask

  task automatic test_store_hold();
    logic [W+4:0] e;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, (c < 5) ? 1 : 0, 1, 9, (c < 4) ? 1 : 0, 0);
      @(negedge in_clk);
      e = mk(0, (c == 4) ? 1 : 0, (c == 5 || c == 6) ? 1 : 0, (c == 6) ? 1 : 0, 1, 9);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL store_hold c%0d: got %h want %h", c, obs(), e); end
      if (c == 4) begin
        checks++;
        if (out_stall_cycles !== 16'd4) begin errors++; $display("FAIL store_stall: got %0d want 4", out_stall_cycles); end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    logic [W+4:0] e;
    logic [W+4:0] exp_tab [9];
    do_reset();
    exp_tab[0] = mk(1, 0, 0, 0, 0, 0);
    exp_tab[1] = mk(0, 1, 1, 1, 0, 12);
    exp_tab[2] = mk(0, 0, 1, 0, 0, 0);
    exp_tab[3] = mk(0, 0, 0, 0, 0, 0);
    exp_tab[4] = mk(0, 0, 0, 0, 0, 0);
    exp_tab[5] = mk(1, 0, 0, 0, 0, 0);
    exp_tab[6] = mk(0, 0, 1, 1, 0, 15);
    exp_tab[7] = mk(1, 0, 0, 0, 0, 0);
    exp_tab[8] = mk(0, 0, 1, 1, 0, 16);
    for (int c = 0; c < 9; c++) begin
      case (c)
        0:       drive(1, 12, 0, 0, 0, 0, 0);
        1:       drive(0, 0, 1, 0, 11, 0, 0);
        2:       drive(1, 14, 0, 0, 0, 0, 1);
        5:       drive(1, 15, 0, 0, 0, 0, 0);
        6:       drive(1, 16, 1, 0, 17, 0, 1);
        7:       drive(1, 16, 1, 0, 17, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge in_clk);
      e = exp_tab[c];
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL flush c%0d: got %h want %h", c, obs(), e); end
      next_cycle();
    end
    @(negedge in_clk);
    checks++;
    if (out_stall_cycles !== 16'd0) begin errors++; $display("FAIL flush_stall: got %0d want 0", out_stall_cycles); end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    logic [W+4:0] e;
    do_reset();
    drive(0, 0, 1, 0, 7, 0, 0); next_cycle();
    drive(1, 2, 0, 0, 0, 0, 0); next_cycle();
    next_cycle();
    drive(1, 3, 0, 0, 0, 0, 0);
    @(negedge in_clk); e = mk(1, 0, 1, 1, 0, 2);
    checks++; if (obs() !== e || out_stall_cycles !== 16'd1) begin errors++; $display("FAIL midrst_pre: got %h cnt=%0d want %h cnt=1", obs(), out_stall_cycles, e); end
    #1 in_rst = 1'b1;
    #1;
    checks++;
    if (obs() !== '0 || out_stall_cycles !== '0 || {out_wb_from_ls, out_wb_rob_idx} !== '0) begin
      errors++; $display("FAIL midrst_zero: got %h idx=%h cnt=%0d want all 0", obs(), out_wb_rob_idx, out_stall_cycles);
    end
    @(posedge in_clk); #1 in_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge in_clk);
      checks++; if (obs() !== '0) begin errors++; $display("FAIL midrst_after c%0d: got %h want 0", c, obs()); end
      next_cycle();
    end
    drive(0, 0, 1, 0, 8, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 in_rst = 1'b1;
    #1;
    checks++; if (obs() !== '0) begin errors++; $display("FAIL midrst_ls: got %h want 0", obs()); end
    @(posedge in_clk); #1 in_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge in_clk);
      checks++; if (obs() !== '0) begin errors++; $display("FAIL midrst_ls_after c%0d: got %h want 0", c, obs()); end
      next_cycle();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(0, 0, 1, 1, 4, 1, 0);
    repeat (65534) @(posedge in_clk);
    @(negedge in_clk);
    checks++; if (out_stall_cycles !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", out_stall_cycles); end
    repeat (10) @(posedge in_clk);
    @(negedge in_clk);
    checks++; if (out_stall_cycles !== 16'hFFFF || out_ls_grant !== 1'b0) begin errors++; $display("FAIL sat_hold: got %h g=%b want ffff g=0", out_stall_cycles, out_ls_grant); end
    next_cycle();
  endtask

  // Reference model: writebacks booked by absolute due cycle; busy = anything still booked.
  task automatic test_random();
    ent_t        pend [int];
    int          now;
    bit          alu_fav;
    int unsigned cnt;
    now = 0; alu_fav = 1'b1; cnt = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int ar, lr, st, sp, fl, ai, li;
      bit a_ok, l_ok, ga, gl, v;
      logic [W+4:0] e;
      ent_t cur;
      ar = ($urandom_range(3) != 0) ? 1 : 0;
      lr = ($urandom_range(3) != 0) ? 1 : 0;
      st = int'($urandom_range(1));
      sp = ($urandom_range(3) == 0) ? 1 : 0;
      fl = ($urandom_range(31) == 0) ? 1 : 0;
      ai = int'($urandom_range(63));
      li = int'($urandom_range(63));
      drive(ar, ai, lr, st, li, sp, fl);
      a_ok = (ar != 0) && !pend.exists(now + ALU_LAT);
      l_ok = (lr != 0) && !(st != 0 && sp != 0);
      ga = 1'b0; gl = 1'b0;
      if (fl == 0) begin
        if (a_ok && (alu_fav || !l_ok)) ga = 1'b1;
        else if (l_ok && !(alu_fav && ar != 0)) gl = 1'b1;
      end
      v   = pend.exists(now);
      cur = v ? pend[now] : '0;
      e   = mk(ga, gl, (pend.num() > 0) ? 1 : 0, v, cur.ls, cur.idx);
      @(negedge in_clk);
      checks++;
      if (obs() !== e || out_stall_cycles !== cnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL random c%0d: got %h cnt=%0d want %h cnt=%0d", c, obs(), out_stall_cycles, e, cnt);
      end
      @(posedge in_clk);
      if (fl != 0) begin
        pend.delete();
        alu_fav = 1'b1;
      end else begin
        if (ga) begin pend[now + ALU_LAT] = {1'b0, ai[W-1:0]}; alu_fav = 1'b0; end
        if (gl) begin pend[now + LS_LAT] = {1'b1, li[W-1:0]}; alu_fav = 1'b1; end
        if ((ar != 0 || lr != 0) && !ga && !gl && cnt < 65535) cnt++;
      end
      if (pend.exists(now)) pend.delete(now);
      now++;
      #1;
    end
  endtask

  initial begin
    in_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_stream();
    test_ls_then_alu();
    test_both_continuous();
    test_store_hold();
    test_flush();
    test_reset_midflight();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
